// File: rtl/axi_lite_rr_arbiter.sv
// N-master to 1-slave AXI-lite arbiter that locks the slave for one whole read or write transaction.
// Define AXI_ARB_RR_EN for round-robin grants; leave it undefined for fixed priority (lowest index wins).
module axi_lite_rr_arbiter #(
    parameter int N_MASTERS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_araddr_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_awaddr_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    input  logic [N_MASTERS*STRB_WIDTH-1:0] m_wstrb_i,
    input  logic [N_MASTERS-1:0]            m_arvalid_i,
    input  logic [N_MASTERS-1:0]            m_rready_i,
    input  logic [N_MASTERS-1:0]            m_awvalid_i,
    input  logic [N_MASTERS-1:0]            m_wvalid_i,
    input  logic [N_MASTERS-1:0]            m_bready_i,
    output logic [N_MASTERS-1:0]            m_arready_o,
    output logic [N_MASTERS-1:0]            m_rvalid_o,
    output logic [N_MASTERS-1:0]            m_awready_o,
    output logic [N_MASTERS-1:0]            m_wready_o,
    output logic [N_MASTERS-1:0]            m_bvalid_o,
    output logic [N_MASTERS*DATA_WIDTH-1:0] m_rdata_o,
    output logic [N_MASTERS*2-1:0]          m_bresp_o,
    output logic [ADDR_WIDTH-1:0]           araddr_o,
    output logic [ADDR_WIDTH-1:0]           awaddr_o,
    output logic [DATA_WIDTH-1:0]           wdata_o,
    output logic [STRB_WIDTH-1:0]           wstrb_o,
    output logic                            arvalid_o,
    output logic                            rready_o,
    output logic                            awvalid_o,
    output logic                            wvalid_o,
    output logic                            bready_o,
    input  logic                            arready_i,
    input  logic                            rvalid_i,
    input  logic                            awready_i,
    input  logic                            wready_i,
    input  logic                            bvalid_i,
    input  logic [DATA_WIDTH-1:0]           rdata_i,
    input  logic [1:0]                      bresp_i
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IDX_W-1:0]     grant_q;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_valid;
    logic                 ar_done_q;
    logic                 aw_done_q;
    logic                 w_done_q;
    logic [N_MASTERS-1:0] wr_req;
    logic [N_MASTERS-1:0] req;

    assign wr_req = m_awvalid_i | m_wvalid_i;
    assign req    = wr_req | m_arvalid_i;

`ifdef AXI_ARB_RR_EN
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] cand_idx;
    int               cand;

    // Search starts one past the last winner so every requester is served in turn.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            cand     = (int'(last_q) + i) % N_MASTERS;
            cand_idx = IDX_W'(cand);
            if (!win_valid && req[cand_idx]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end
`else
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef AXI_ARB_RR_EN
            last_q    <= IDX_W'(N_MASTERS - 1);
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && win_valid) begin
                grant_q <= win_idx;
`ifdef AXI_ARB_RR_EN
                last_q  <= win_idx;
`endif
            end
            if (state_q != IDLE && state_d == IDLE) begin
                ar_done_q <= 1'b0;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (arvalid_o && arready_i) ar_done_q <= 1'b1;
                if (awvalid_o && awready_i) aw_done_q <= 1'b1;
                if (wvalid_o && wready_i)   w_done_q  <= 1'b1;
            end
        end
    end

    // A write request from the winner takes precedence over its read request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_valid) state_d = wr_req[win_idx] ? WR : RD;
            RD:      if (rvalid_i && rready_o) state_d = IDLE;
            WR:      if (bvalid_i && bready_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_arready_o = '0;
        m_rvalid_o  = '0;
        m_awready_o = '0;
        m_wready_o  = '0;
        m_bvalid_o  = '0;
        m_rdata_o   = '0;
        m_bresp_o   = '0;
        araddr_o    = '0;
        awaddr_o    = '0;
        wdata_o     = '0;
        wstrb_o     = '0;
        arvalid_o   = 1'b0;
        rready_o    = 1'b0;
        awvalid_o   = 1'b0;
        wvalid_o    = 1'b0;
        bready_o    = 1'b0;
        case (state_q)
            RD: begin
                araddr_o             = m_araddr_i[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
                arvalid_o            = m_arvalid_i[grant_q] & ~ar_done_q;
                m_arready_o[grant_q] = arready_i & ~ar_done_q;
                rready_o             = m_rready_i[grant_q];
                m_rvalid_o[grant_q]  = rvalid_i;
                m_rdata_o[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] = rdata_i;
            end
            WR: begin
                // Done flags keep a master that still holds valid from repeating AW or W.
                awaddr_o             = m_awaddr_i[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
                awvalid_o            = m_awvalid_i[grant_q] & ~aw_done_q;
                m_awready_o[grant_q] = awready_i & ~aw_done_q;
                wdata_o              = m_wdata_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                wstrb_o              = m_wstrb_i[int'(grant_q)*STRB_WIDTH +: STRB_WIDTH];
                wvalid_o             = m_wvalid_i[grant_q] & ~w_done_q;
                m_wready_o[grant_q]  = wready_i & ~w_done_q;
                bready_o             = m_bready_i[grant_q];
                m_bvalid_o[grant_q]  = bvalid_i;
                m_bresp_o[int'(grant_q)*2 +: 2] = bresp_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter: a 2-master instance for transactions and a 3-master one for grant order.
// Expected grant order follows AXI_ARB_RR_EN exactly as the design is built.
`timescale 1ns/1ps
module tb_axi_lite_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [63:0] m_araddr, m_awaddr, m_wdata, m_rdata;
    logic [7:0]  m_wstrb;
    logic [1:0]  m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic [1:0]  m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
    logic [3:0]  m_bresp;
    logic [31:0] araddr_o, awaddr_o, wdata_o, rdata;
    logic [3:0]  wstrb_o;
    logic        arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [1:0]  bresp;

    logic [95:0] m_araddr_3, m_awaddr_3, m_wdata_3, m_rdata_3;
    logic [11:0] m_wstrb_3;
    logic [2:0]  m_arvalid_3, m_rready_3, m_awvalid_3, m_wvalid_3, m_bready_3;
    logic [2:0]  m_arready_3, m_rvalid_3, m_awready_3, m_wready_3, m_bvalid_3;
    logic [5:0]  m_bresp_3;
    logic [31:0] araddr_3, awaddr_3, wdata_3, rdata_3;
    logic [3:0]  wstrb_3;
    logic        arvalid_3, rready_3, awvalid_3, wvalid_3, bready_3;
    logic        arready_3, rvalid_3, awready_3, wready_3, bvalid_3;
    logic [1:0]  bresp_3;

    int          total = 0;
    int          bad = 0;
    int          ar_hs = 0;
    int          aw_hs = 0;
    int          w_hs = 0;
    int          ar_base, aw_base, w_base;
    int          n_grants = 0;
    logic [2:0]  grants [4];

    always #5 clk = ~clk;

    axi_lite_rr_arbiter #(.N_MASTERS(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_araddr_i(m_araddr), .m_awaddr_i(m_awaddr), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
        .m_arvalid_i(m_arvalid), .m_rready_i(m_rready), .m_awvalid_i(m_awvalid),
        .m_wvalid_i(m_wvalid), .m_bready_i(m_bready),
        .m_arready_o(m_arready), .m_rvalid_o(m_rvalid), .m_awready_o(m_awready),
        .m_wready_o(m_wready), .m_bvalid_o(m_bvalid), .m_rdata_o(m_rdata), .m_bresp_o(m_bresp),
        .araddr_o(araddr_o), .awaddr_o(awaddr_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .arvalid_o(arvalid_o), .rready_o(rready_o), .awvalid_o(awvalid_o),
        .wvalid_o(wvalid_o), .bready_o(bready_o),
        .arready_i(arready), .rvalid_i(rvalid), .awready_i(awready), .wready_i(wready),
        .bvalid_i(bvalid), .rdata_i(rdata), .bresp_i(bresp)
    );

    axi_lite_rr_arbiter #(.N_MASTERS(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .m_araddr_i(m_araddr_3), .m_awaddr_i(m_awaddr_3), .m_wdata_i(m_wdata_3), .m_wstrb_i(m_wstrb_3),
        .m_arvalid_i(m_arvalid_3), .m_rready_i(m_rready_3), .m_awvalid_i(m_awvalid_3),
        .m_wvalid_i(m_wvalid_3), .m_bready_i(m_bready_3),
        .m_arready_o(m_arready_3), .m_rvalid_o(m_rvalid_3), .m_awready_o(m_awready_3),
        .m_wready_o(m_wready_3), .m_bvalid_o(m_bvalid_3), .m_rdata_o(m_rdata_3), .m_bresp_o(m_bresp_3),
        .araddr_o(araddr_3), .awaddr_o(awaddr_3), .wdata_o(wdata_3), .wstrb_o(wstrb_3),
        .arvalid_o(arvalid_3), .rready_o(rready_3), .awvalid_o(awvalid_3),
        .wvalid_o(wvalid_3), .bready_o(bready_3),
        .arready_i(arready_3), .rvalid_i(rvalid_3), .awready_i(awready_3), .wready_i(wready_3),
        .bvalid_i(bvalid_3), .rdata_i(rdata_3), .bresp_i(bresp_3)
    );

    // Handshake counters and the grant order of the 3-master instance.
    always @(posedge clk) begin
        if (arvalid_o && arready) ar_hs++;
        if (awvalid_o && awready) aw_hs++;
        if (wvalid_o && wready)   w_hs++;
        if (arvalid_3 && arready_3 && n_grants < 4) begin
            grants[n_grants] = m_arready_3;
            n_grants++;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] arv, input logic [1:0] awv, input logic [1:0] wv,
                                 input logic [1:0] rr, input logic [1:0] br);
        m_arvalid = arv;
        m_awvalid = awv;
        m_wvalid  = wv;
        m_rready  = rr;
        m_bready  = br;
    endtask

    initial begin
        logic [2:0] exp_grant [4];
`ifdef AXI_ARB_RR_EN
        exp_grant = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp_grant = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        rst_n = 1'b0;
        m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rdata = '0; bresp = '0;
        m_araddr_3 = '0; m_awaddr_3 = '0; m_wdata_3 = '0; m_wstrb_3 = '0;
        m_arvalid_3 = '0; m_rready_3 = '0; m_awvalid_3 = '0; m_wvalid_3 = '0; m_bready_3 = '0;
        arready_3 = 1'b0; rvalid_3 = 1'b0; awready_3 = 1'b0; wready_3 = 1'b0; bvalid_3 = 1'b0;
        rdata_3 = '0; bresp_3 = '0;
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b10, 2'b00);
        arready = 1'b1;

        #12;
        checkOutput("rst_slave_valids", 64'({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}), 64'd0);
        checkOutput("rst_master_hs", 64'({m_arready, m_rvalid, m_awready, m_wready, m_bvalid}), 64'd0);
        checkOutput("rst_araddr", 64'(araddr_o), 64'd0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        arready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Three masters reading continuously.
        m_arvalid_3 = 3'b111; m_rready_3 = 3'b111; arready_3 = 1'b1; rvalid_3 = 1'b1;
        rdata_3 = 32'h0000_0055;
        repeat (12) @(negedge clk);
        m_arvalid_3 = '0; m_rready_3 = '0; arready_3 = 1'b0; rvalid_3 = 1'b0;
        checkOutput("rr_count", 64'(n_grants), 64'd4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(exp_grant[i]));

        // Single read by master 1 with R delayed five cycles.
        ar_base = ar_hs;
        m_araddr = {32'h8000_0010, 32'h0};
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b10, 2'b00);
        #1 checkOutput("rd_latency", 64'(arvalid_o), 64'd0);
        @(negedge clk);
        arready = 1'b1;
        #1;
        checkOutput("rd_arvalid", 64'(arvalid_o), 64'd1);
        checkOutput("rd_araddr", 64'(araddr_o), 64'h8000_0010);
        checkOutput("rd_arready", 64'(m_arready), 64'h2);
        checkOutput("rd_no_wr_chan", 64'({awvalid_o, wvalid_o, bready_o}), 64'd0);
        repeat (5) begin
            @(negedge clk);
            #1 checkOutput("rd_dup_arvalid", 64'({arvalid_o, m_arready}), 64'd0);
        end
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        #1;
        checkOutput("rd_rvalid", 64'(m_rvalid), 64'h2);
        checkOutput("rd_rdata", m_rdata, 64'hDEAD_BEEF_0000_0000);
        checkOutput("rd_rready", 64'(rready_o), 64'd1);
        @(negedge clk);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        rvalid = 1'b0; arready = 1'b0;
        #1;
        checkOutput("rd_ar_hs_once", 64'(ar_hs - ar_base), 64'd1);
        checkOutput("rd_idle_outs", 64'({arvalid_o, m_rvalid, rready_o}), 64'd0);

        // Master 0 write with W one cycle ahead of AW.
        aw_base = aw_hs; w_base = w_hs;
        m_wdata = {32'h0, 32'h1234_5678}; m_wstrb = 8'h0F; m_awaddr = {32'h0, 32'h0000_0100};
        awready = 1'b1; wready = 1'b1;
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        @(negedge clk);
        #1;
        checkOutput("wr_wvalid", 64'(wvalid_o), 64'd1);
        checkOutput("wr_wdata", 64'(wdata_o), 64'h1234_5678);
        checkOutput("wr_wstrb", 64'(wstrb_o), 64'hF);
        checkOutput("wr_wready", 64'(m_wready), 64'h1);
        checkOutput("wr_no_aw_yet", 64'(awvalid_o), 64'd0);
        checkOutput("wr_no_rd_chan", 64'({arvalid_o, rready_o, m_rvalid}), 64'd0);
        @(negedge clk);
        applyStimulus(2'b00, 2'b01, 2'b01, 2'b00, 2'b01);
        #1;
        checkOutput("wr_w_suppressed", 64'(wvalid_o), 64'd0);
        checkOutput("wr_awvalid", 64'(awvalid_o), 64'd1);
        checkOutput("wr_awaddr", 64'(awaddr_o), 64'h100);
        @(negedge clk);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
        bvalid = 1'b1; bresp = 2'b00;
        #1;
        checkOutput("wr_aw_suppressed", 64'(awvalid_o), 64'd0);
        checkOutput("wr_bvalid", 64'(m_bvalid), 64'h1);
        checkOutput("wr_bready", 64'(bready_o), 64'd1);
        @(negedge clk);
        bvalid = 1'b0;
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        #1;
        checkOutput("wr_aw_hs_once", 64'(aw_hs - aw_base), 64'd1);
        checkOutput("wr_w_hs_once", 64'(w_hs - w_base), 64'd1);
        checkOutput("wr_idle_bvalid", 64'(m_bvalid), 64'd0);

        // Master 0 asks for read and write together: write goes first.
        m_araddr = {32'h0, 32'h0000_0200}; arready = 1'b1;
        applyStimulus(2'b01, 2'b01, 2'b01, 2'b01, 2'b01);
        @(negedge clk);
        #1;
        checkOutput("wbr_wr_first", 64'({awvalid_o, wvalid_o, arvalid_o}), 64'b110);
        @(negedge clk);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        bvalid = 1'b1; bresp = 2'b10;
        #1;
        checkOutput("wbr_bresp", 64'(m_bresp), 64'h2);
        checkOutput("wbr_arvalid_in_wr", 64'(arvalid_o), 64'd0);
        @(negedge clk);
        bvalid = 1'b0;
        #1 checkOutput("wbr_turnaround", 64'({arvalid_o, awvalid_o}), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("wbr_rd_follows", 64'(arvalid_o), 64'd1);
        checkOutput("wbr_araddr", 64'(araddr_o), 64'h200);
        @(negedge clk);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        #1 checkOutput("wbr_rdata", m_rdata, 64'h0000_0000_CAFE_F00D);
        @(negedge clk);
        rvalid = 1'b0;
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        // Reset lands in the middle of a master 1 write, after AW.
        m_awaddr = {32'h0000_0300, 32'h0}; awready = 1'b1; wready = 1'b0;
        applyStimulus(2'b00, 2'b10, 2'b10, 2'b00, 2'b10);
        @(negedge clk);
        #1;
        checkOutput("rstw_awready", 64'(m_awready), 64'h2);
        checkOutput("rstw_awaddr", 64'(awaddr_o), 64'h300);
        @(negedge clk);
        #1 checkOutput("rstw_after_aw", 64'({awvalid_o, wvalid_o}), 64'b01);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstw_slave_outs", 64'({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}), 64'd0);
        checkOutput("rstw_master_outs", 64'({m_arready, m_awready, m_wready, m_bvalid}), 64'd0);
        checkOutput("rstw_addr", 64'(awaddr_o), 64'd0);
        m_araddr = {32'h0000_00B1, 32'h0000_00A0};
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rstw_first_grant", 64'(m_arready), 64'h1);
        checkOutput("rstw_first_addr", 64'(araddr_o), 64'hA0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b0;
        #10;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
